// File: rtl/iir_coeff_ctrl.sv
// Runtime coefficient controller for a cascaded-SOS IIR filter.
// Holds a shadow and an active coefficient bank, feeds the active bank to the
// filter and sequences a glitch-free bank swap: gate samples, drain the filter
// pipeline, swap, then hold the filter state clear for a few cycles.
// Optional build macro: IIR_COEFF_READBACK_EN adds a registered read port
// (rd_addr, rd_bank, rd_data) onto either bank.
module iir_coeff_ctrl #(
    parameter int  Nsos   = 3,
    parameter int  Ncint  = 4,
    parameter int  Ncfrac = 14,
    parameter int  Nlat   = 16,
    parameter int  Nflush = 4,
    // Reset contents of both banks, per section {b0, b1, b2, a0, a1, a2}.
    // Section 2 deliberately holds out-of-range taps that saturate.
    parameter real coeff [0:Nsos-1][0:5] = '{
        '{0.0625, 0.125, 0.0625, 1.0, -1.8066406250, 0.83},
        '{0.25,  -0.5,   0.25,   1.0, -1.5,          0.5625},
        '{1.0,    9.0,  -9.0,    1.0, -0.75,         0.125}
    },
    localparam int Ncoef = 6 * Nsos,
    localparam int Wc    = Ncint + Ncfrac,
    localparam int AW    = $clog2(Ncoef)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [Wc-1:0]       wr_data,
    output logic                wr_err,
    input  logic                commit,
    output logic                busy,
    output logic                commit_done,
    input  logic                dv_in,
    input  logic [17:0]         d_in,
    output logic                dv_filt,
    output logic [17:0]         d_filt,
    output logic                filt_clr,
    output logic [Ncoef*Wc-1:0] coeff_act,
    output logic [15:0]         drop_cnt
`ifdef IIR_COEFF_READBACK_EN
    ,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_bank,
    output logic [Wc-1:0]       rd_data
`endif
);

    // Counter must hold the larger of the two load values (Nlat-1, Nflush-1).
    localparam int CW = $clog2(((Nlat > Nflush) ? Nlat : Nflush) + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Quantise the real reset table: round to nearest, saturate to Wc bits.
    function automatic logic [Ncoef*Wc-1:0] init_bank();
        logic [Ncoef*Wc-1:0] bank;
        real                 scaled;
        longint              q;
        longint              qmax;
        longint              qmin;
        bank = '0;
        qmax = (64'sd1 <<< (Wc - 1)) - 64'sd1;
        qmin = -(64'sd1 <<< (Wc - 1));
        for (int s = 0; s < Nsos; s++) begin
            for (int t = 0; t < 6; t++) begin
                scaled = coeff[s][t] * (2.0 ** Ncfrac);
                if (scaled >= real'(qmax)) begin
                    q = qmax;
                end else if (scaled <= real'(qmin)) begin
                    q = qmin;
                end else begin
                    q = longint'(scaled);
                end
                bank[(6 * s + t) * Wc +: Wc] = q[Wc-1:0];
            end
        end
        return bank;
    endfunction

    localparam logic [Ncoef*Wc-1:0] INIT_BANK = init_bank();

    state_t              state_r;
    state_t              next_state_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_next_s;
    logic [Ncoef*Wc-1:0] shadow_r;
    logic                addr_ok_s;

    // Write address range check, shared by the shadow write and wr_err.
    always_comb begin
        addr_ok_s = 1'b0;
        if (int'(wr_addr) < Ncoef) begin
            addr_ok_s = 1'b1;
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // Next-state and sequencing counter: drain Nlat cycles, swap, flush Nflush cycles.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (commit) begin
                    next_state_s = DRAIN;
                    cnt_next_s   = CW'(Nlat - 1);
                end else begin
                    next_state_s = IDLE;
                    cnt_next_s   = '0;
                end
            end
            DRAIN: begin
                if (cnt_r == '0) begin
                    next_state_s = SWAP;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = DRAIN;
                    cnt_next_s   = cnt_r - CW'(1);
                end
            end
            SWAP: begin
                next_state_s = FLUSH;
                cnt_next_s   = CW'(Nflush - 1);
            end
            FLUSH: begin
                if (cnt_r == '0) begin
                    next_state_s = IDLE;
                    cnt_next_s   = '0;
                end else begin
                    next_state_s = FLUSH;
                    cnt_next_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // FSM state and counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            filt_clr    <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            busy        <= (next_state_s != IDLE);
            filt_clr    <= (next_state_s == FLUSH);
            commit_done <= (state_r == FLUSH) && (next_state_s == IDLE);
        end
    end

    // Sample gate: pass in IDLE, otherwise discard and count drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_filt  <= 1'b0;
            d_filt   <= 18'd0;
            drop_cnt <= 16'd0;
        end else if (state_r == IDLE) begin
            dv_filt <= dv_in;
            d_filt  <= d_in;
            if (commit) begin
                drop_cnt <= 16'd0;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end else begin
            dv_filt <= 1'b0;
            d_filt  <= 18'd0;
            if (dv_in && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

    // Coefficient banks: shadow takes writes in any state; active loads on SWAP.
    // SWAP reads the shadow before this cycle's write lands (non-blocking).
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r  <= INIT_BANK;
            coeff_act <= INIT_BANK;
            wr_err    <= 1'b0;
        end else begin
            if (wr_en && addr_ok_s) begin
                shadow_r[int'(wr_addr) * Wc +: Wc] <= wr_data;
            end else begin
                shadow_r <= shadow_r;
            end
            wr_err <= wr_en && !addr_ok_s;
            if (state_r == SWAP) begin
                coeff_act <= shadow_r;
            end else begin
                coeff_act <= coeff_act;
            end
        end
    end

`ifdef IIR_COEFF_READBACK_EN
    // Registered readback; a same-cycle write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (int'(rd_addr) >= Ncoef) begin
            rd_data <= '0;
        end else if (rd_bank) begin
            rd_data <= shadow_r[int'(rd_addr) * Wc +: Wc];
        end else begin
            rd_data <= coeff_act[int'(rd_addr) * Wc +: Wc];
        end
    end
`endif

endmodule
